// File: rtl/fifo_memory_pkg.sv
// Shared defaults and width helpers for the fifo_memory block.
package fifo_memory_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  // Depth is at least 2, so the pointer is always at least one bit wide.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_memory_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read.
module fifo_memory_ram
  import fifo_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  parameter int AW         = ptr_width(DEF_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read returns the pre-write word when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_memory.sv
// Synchronous FIFO with pointer/count control; storage lives in fifo_memory_ram.
// Optional OVERFLOW/UNDERFLOW pulses are enabled by defining FIFO_MEMORY_OVF_UDF_EN.
module fifo_memory
  import fifo_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
`ifdef FIFO_MEMORY_OVF_UDF_EN
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
`endif
  output logic                  EMPTY,
  output logic                  FULL
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          wr_ok, rd_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign EMPTY = (count == '0);
  assign FULL  = (count == CW'(FIFO_DEPTH));

  // A read frees a slot on the same edge, so a full FIFO still accepts WR+RD.
  assign wr_ok = WR && (!FULL || RD);
  assign rd_ok = RD && !EMPTY;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= ptr_next(wptr);
      if (rd_ok) rptr <= ptr_next(rptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_MEMORY_OVF_UDF_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= WR && FULL && !RD;
      UNDERFLOW <= RD && EMPTY;
    end
  end
`endif

  fifo_memory_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk   (Clk),
    .rst   (Rst),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (dataIn),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_fifo_memory.sv
// Directed self-checking bench for fifo_memory (DATA_WIDTH=8, FIFO_DEPTH=16).
module tb_fifo_memory;

  logic       Clk = 1'b0;
  logic       Rst, WR, RD;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       EMPTY, FULL;
`ifdef FIFO_MEMORY_OVF_UDF_EN
  logic       OVERFLOW, UNDERFLOW;
`endif

  int checks = 0;
  int errors = 0;

  fifo_memory #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .WR        (WR),
    .RD        (RD),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
`ifdef FIFO_MEMORY_OVF_UDF_EN
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
`endif
    .EMPTY     (EMPTY),
    .FULL      (FULL)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    Rst = r; WR = w; RD = rd; dataIn = d;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset overrides simultaneous WR/RD
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    check("rst_empty", 16'(EMPTY), 16'd1);
    check("rst_full", 16'(FULL), 16'd0);
    check("rst_dout", 16'(dataOut), 16'h00);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      check("fill_empty", 16'(EMPTY), 16'd0);
      check("fill_full", 16'(FULL), (i == 15) ? 16'd1 : 16'd0);
    end

    // Write when full is discarded
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    check("ovf_full", 16'(FULL), 16'd1);
    check("ovf_dout", 16'(dataOut), 16'h00);
`ifdef FIFO_MEMORY_OVF_UDF_EN
    check("ovf_pulse", 16'(OVERFLOW), 16'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_full", 16'(FULL), 16'd1);
`ifdef FIFO_MEMORY_OVF_UDF_EN
    check("ovf_clear", 16'(OVERFLOW), 16'd0);
`endif

    // Drain 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain_dout", 16'(dataOut), 16'(i));
      check("drain_full", 16'(FULL), 16'd0);
      check("drain_empty", 16'(EMPTY), (i == 15) ? 16'd1 : 16'd0);
    end

    // Read on empty is ignored
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("udf_dout", 16'(dataOut), 16'h0F);
    check("udf_empty", 16'(EMPTY), 16'd1);
`ifdef FIFO_MEMORY_OVF_UDF_EN
    check("udf_pulse", 16'(UNDERFLOW), 16'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef FIFO_MEMORY_OVF_UDF_EN
    check("udf_clear", 16'(UNDERFLOW), 16'd0);
`endif

    // WR+RD on empty: write accepted, no fall-through
    step(1'b0, 1'b1, 1'b1, 8'h33);
    check("sim_empty_empty", 16'(EMPTY), 16'd0);
    check("sim_empty_dout", 16'(dataOut), 16'h0F);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("sim_empty_read", 16'(dataOut), 16'h33);
    check("sim_empty_after", 16'(EMPTY), 16'd1);

    // Refill 0x10..0x1F, then WR+RD on full with 0x55
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(16 + i));
    check("refill_full", 16'(FULL), 16'd1);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("sim_full_dout", 16'(dataOut), 16'h10);
    check("sim_full_full", 16'(FULL), 16'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("sim_full_drain", 16'(dataOut), (i == 15) ? 16'h55 : 16'(17 + i));
    end
    check("sim_full_empty", 16'(EMPTY), 16'd1);

    // 40 write/read pairs walk the pointers around several times
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("wrap_dout", 16'(dataOut), 16'(8'h80 + i));
      check("wrap_empty", 16'(EMPTY), 16'd1);
    end

    // Mid-stream reset discards queued words
    step(1'b0, 1'b1, 1'b0, 8'hC1);
    step(1'b0, 1'b1, 1'b0, 8'hC2);
    step(1'b0, 1'b1, 1'b0, 8'hC3);
    check("pre_rst_empty", 16'(EMPTY), 16'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("mid_rst_empty", 16'(EMPTY), 16'd1);
    check("mid_rst_dout", 16'(dataOut), 16'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_rst_rd_ignored", 16'(dataOut), 16'h00);
    step(1'b0, 1'b1, 1'b0, 8'hD1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("post_rst_dout", 16'(dataOut), 16'hD1);
    check("post_rst_empty", 16'(EMPTY), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
